random_range: RTL

RANDOM_RANGE -- requirements
Module: random_range

---
 rtl/random_pkg.sv | 25 ++
 rtl/range_wrap_add.sv | 28 ++
 rtl/random_range.sv | 116 +++++++++++
 3 files changed

// File: rtl/random_pkg.sv
// Shared types and constants for the random_range block: cursor step
// encoding, LFSR seed/taps and the step-to-delta helper.
package random_pkg;

  typedef enum logic [1:0] {
    STEP_P2,
    STEP_M2,
    STEP_P1,
    STEP_M1
  } step_e;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic signed [2:0] step_delta(input step_e s);
    case (s)
      STEP_P2: return 3'sd2;
      STEP_M2: return -3'sd2;
      STEP_P1: return 3'sd1;
      default: return -3'sd1;
    endcase
  endfunction

endpackage

// File: rtl/range_wrap_add.sv
// Adds a small signed step (|step| <= 2) to a value in [LO,HI], wrapping
// modulo the range size so the result stays in [LO,HI].
module range_wrap_add #(
  parameter int LO    = 1,
  parameter int HI    = 12,
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]  value,
  input  logic signed [2:0] step,
  output logic [WIDTH-1:0]  result
);

  localparam int N = HI - LO + 1;

  int offset;

  // The range holds at least two values and the step is at most 2, so a
  // single correction always lands back inside [0,N).
  always_comb begin
    offset = int'(value) - LO + int'(step);
    if (offset >= N)
      offset = offset - N;
    else if (offset < 0)
      offset = offset + N;
    result = WIDTH'(offset + LO);
  end

endmodule

// File: rtl/random_range.sv
// Keystroke-driven cursor that is sampled on draw to produce a value in
// [LO,HI]. Define RANDOM_RANGE_LFSR_EN to mix a 16-bit LFSR into each draw.
module random_range
  import random_pkg::*;
#(
  parameter int LO        = 1,
  parameter int HI        = 12,
  parameter int WIDTH     = 4,
  parameter int NO_REPEAT = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             up,
  input  logic             down,
  input  logic             right,
  input  logic             left,
  input  logic             draw,
  output logic [WIDTH-1:0] random,
  output logic             valid
);

  localparam int             N    = HI - LO + 1;
  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);

  if (!(LO < HI && HI < (1 << WIDTH))) begin : g_bad_range
    $error("random_range: parameters must satisfy LO < HI < 2**WIDTH");
  end

  logic [WIDTH-1:0]  cursor;
  logic [WIDTH-1:0]  cursor_next;
  logic [WIDTH-1:0]  candidate;
  logic [WIDTH-1:0]  candidate_inc;
  logic [WIDTH-1:0]  drawn;
  logic              have_prev;
  step_e             step_sel;
  logic signed [2:0] step_val;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    step_sel = STEP_P1;
    if (right)
      step_sel = STEP_P2;
    else if (left)
      step_sel = STEP_M2;
    else if (up)
      step_sel = STEP_P1;
    else if (down)
      step_sel = STEP_M1;
  end

  assign step_val = step_delta(step_sel);

  range_wrap_add #(.LO(LO), .HI(HI), .WIDTH(WIDTH)) u_cursor_step (
    .value  (cursor),
    .step   (step_val),
    .result (cursor_next)
  );

`ifdef RANDOM_RANGE_LFSR_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  int          cand_off;

  // Keystrokes are folded in after the shift; with no key pressed the XOR is a no-op.
  always_comb begin
    lfsr_next      = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    lfsr_next[3:0] = lfsr_next[3:0] ^ {up, down, right, left};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      lfsr <= LFSR_SEED;
    else
      lfsr <= lfsr_next;
  end

  always_comb begin
    cand_off  = (int'(cursor) - LO + int'(lfsr[7:0])) % N;
    candidate = WIDTH'(LO + cand_off);
  end
`else
  assign candidate = cursor;
`endif

  range_wrap_add #(.LO(LO), .HI(HI), .WIDTH(WIDTH)) u_repeat_inc (
    .value  (candidate),
    .step   (3'sd1),
    .result (candidate_inc)
  );

  always_comb begin
    drawn = candidate;
    if (NO_REPEAT != 0 && have_prev && candidate == random)
      drawn = candidate_inc;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset also kills a pending valid.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cursor    <= LO_V;
      random    <= LO_V;
      valid     <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      cursor <= cursor_next;
      valid  <= draw;
      if (draw) begin
        random    <= drawn;
        have_prev <= 1'b1;
      end
    end
  end

endmodule
